// File: rtl/level_loader_if.sv
// Control and brick-memory bundle for level_loader. The master side (the requester) drives
// start/abort/modes. The slave side (the loader) drives status, draw requests and the write port.
interface level_loader_if;
  logic       start;
  logic       abort;
  logic [1:0] level;
  logic       clear;
  logic       skip_empty;
  logic       busy;
  logic       draw;
  logic       we;
  logic [9:0] addr;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [1:0] health;
  logic       done;

  modport master (
    output start, abort, level, clear, skip_empty,
    input  busy, draw, we, addr, x_out, y_out, health, done
  );

  modport slave (
    input  start, abort, level, clear, skip_empty,
    output busy, draw, we, addr, x_out, y_out, health, done
  );
endinterface

// File: rtl/level_loader.sv
// Walks every brick slot. For each slot it looks up the health for the latched level,
// derives the screen origin with incremental adders, requests a draw, waits, and writes it.
module level_loader #(
  parameter int BRICK_NUM  = 40,
  parameter int COLS       = 10,
  parameter int BRICK_W    = 32,
  parameter int BRICK_H    = 16,
  parameter int X_ORG      = 16,
  parameter int Y_ORG      = 8,
  parameter int DRAW_DELAY = 4
) (
  input logic           clk,
  input logic           resetn,
  level_loader_if.slave bus
);
  localparam logic [9:0]  LAST_SLOT = 10'(BRICK_NUM - 1);
  localparam logic [9:0]  LAST_COL  = 10'(COLS - 1);
  localparam logic [9:0]  PITCH_X   = 10'(BRICK_W);
  localparam logic [9:0]  PITCH_Y   = 10'(BRICK_H);
  localparam logic [9:0]  ORG_X     = 10'(X_ORG);
  localparam logic [9:0]  ORG_Y     = 10'(Y_ORG);
  localparam logic [19:0] DLY       = 20'(DRAW_DELAY);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lvl_q, lvl_d;
  logic        clr_q, clr_d;
  logic        skp_q, skp_d;
  logic [9:0]  addr_q, addr_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  health_q, health_d;
  logic [19:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        draw_q, draw_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        enter_prep;

  // Built-in level table. Only the parity of the column matters (level 1 checkerboard).
  function automatic logic [1:0] lvl_health(input logic [1:0] lv, input logic clr,
                                            input logic [9:0] r, input logic c0);
    logic [1:0] h;
    h = 2'd0;
    if (!clr) begin
      case (lv)
        2'd0:    h = (r == 10'd0) ? 2'd3 : (r == 10'd1) ? 2'd2 : (r == 10'd2) ? 2'd1 : 2'd0;
        2'd1:    h = (r < 10'd4) ? ((r[0] ^ c0) ? 2'd2 : 2'd1) : 2'd0;
        2'd2:    h = 2'd1;
        default: h = 2'd3;
      endcase
    end
    return h;
  endfunction

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    clr_d      = clr_q;
    skp_d      = skp_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    x_d        = x_q;
    y_d        = y_q;
    health_d   = health_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    draw_d     = 1'b0;
    we_d       = 1'b0;
    done_d     = 1'b0;
    enter_prep = 1'b0;

    // Abort beats everything, including a start in IDLE. Slot outputs keep their values.
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          lvl_d      = bus.level;
          clr_d      = bus.clear;
          skp_d      = bus.skip_empty;
          addr_d     = '0;
          col_d      = '0;
          row_d      = '0;
          x_d        = ORG_X;
          y_d        = ORG_Y;
          enter_prep = 1'b1;
        end
        S_PREP: begin
          busy_d = 1'b1;
          if (DRAW_DELAY > 0 && !(skp_q && health_q == 2'd0)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
        S_WAIT: begin
          busy_d = 1'b1;
          cnt_d  = cnt_q + 20'd1;
          if (cnt_d == DLY) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
        S_WRITE: begin
          if (addr_q == LAST_SLOT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d     = addr_q + 10'd1;
            enter_prep = 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 10'd1;
              x_d   = ORG_X;
              y_d   = y_q + PITCH_Y;
            end else begin
              col_d = col_q + 10'd1;
              x_d   = x_q + PITCH_X;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (enter_prep) begin
        state_d  = S_PREP;
        cnt_d    = '0;
        busy_d   = 1'b1;
        health_d = lvl_health(lvl_d, clr_d, row_d, col_d[0]);
        draw_d   = !(skp_d && health_d == 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      lvl_q    <= '0;
      clr_q    <= 1'b0;
      skp_q    <= 1'b0;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      health_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      draw_q   <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      clr_q    <= clr_d;
      skp_q    <= skp_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      health_q <= health_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      draw_q   <= draw_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.draw   = draw_q;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.x_out  = x_q;
  assign bus.y_out  = y_q;
  assign bus.health = health_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_level_loader.sv
// Directed bench for level_loader. It uses a default-geometry instance and a one-slot,
// zero-delay instance. The expected values below are worked out by hand.
module tb_level_loader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  level_loader_if if0();
  level_loader_if if1();

  level_loader u_dut (.clk(clk), .resetn(resetn), .bus(if0.slave));
  level_loader #(.BRICK_NUM(1), .DRAW_DELAY(0)) u_small (.clk(clk), .resetn(resetn), .bus(if1.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int wr_h[40], wr_x[40], wr_y[40], drawn[40];
  int n_wr, n_draw, done_cyc, first_addr;

  // Launch one load on if0 and log every write and draw until done (bounded).
  task automatic run0(input logic [1:0] lv, input logic cl, input logic sk);
    for (int i = 0; i < 40; i++) begin
      wr_h[i] = -1; wr_x[i] = -1; wr_y[i] = -1; drawn[i] = 0;
    end
    n_wr = 0; n_draw = 0; done_cyc = -1;
    @(negedge clk);
    if0.level = lv; if0.clear = cl; if0.skip_empty = sk; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    first_addr = int'(if0.addr);
    for (int n = 1; n <= 2000; n++) begin
      if (if0.draw) begin
        n_draw++;
        if (if0.addr < 40) drawn[if0.addr] = 1;
      end
      if (if0.we) begin
        n_wr++;
        if (if0.addr < 40) begin
          wr_h[if0.addr] = int'(if0.health);
          wr_x[if0.addr] = int'(if0.x_out);
          wr_y[if0.addr] = int'(if0.y_out);
        end
      end
      if (if0.done) begin
        done_cyc = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_busy"}, int'(if0.busy), 0);
    chk({tag, "_draw"}, int'(if0.draw), 0);
    chk({tag, "_we"}, int'(if0.we), 0);
    chk({tag, "_done"}, int'(if0.done), 0);
    chk({tag, "_addr"}, int'(if0.addr), 0);
    chk({tag, "_x"}, int'(if0.x_out), 0);
    chk({tag, "_y"}, int'(if0.y_out), 0);
    chk({tag, "_health"}, int'(if0.health), 0);
  endtask

  initial begin
    int found, cnt_we, cnt_done, cnt_busy, hsum;
    int s_draw[11], s_we[11], s_done[11], s_busy[11], s_h[11], s_x[11], s_y[11];
    if0.start = 0; if0.abort = 0; if0.level = 0; if0.clear = 0; if0.skip_empty = 0;
    if1.start = 0; if1.abort = 0; if1.level = 0; if1.clear = 0; if1.skip_empty = 0;

    repeat (3) @(negedge clk);
    chk_zero0("rst");
    chk("rst_small_busy", int'(if1.busy), 0);
    chk("rst_small_done", int'(if1.done), 0);
    resetn = 1'b1;

    // Level 0, no modes.
    run0(2'd0, 1'b0, 1'b0);
    chk("l0_done_cyc", done_cyc, 241);
    chk("l0_writes", n_wr, 40);
    chk("l0_draws", n_draw, 40);
    chk("l0_s0_x", wr_x[0], 16);
    chk("l0_s0_y", wr_y[0], 8);
    chk("l0_s0_h", wr_h[0], 3);
    chk("l0_s13_x", wr_x[13], 112);
    chk("l0_s13_y", wr_y[13], 24);
    chk("l0_s13_h", wr_h[13], 2);
    chk("l0_s39_x", wr_x[39], 304);
    chk("l0_s39_y", wr_y[39], 56);
    chk("l0_s39_h", wr_h[39], 0);
    chk("l0_s25_h", wr_h[25], 1);
    chk("l0_done_busy", int'(if0.busy), 0);
    @(negedge clk);
    chk("l0_idle_done", int'(if0.done), 0);
    chk("l0_idle_addr_hold", int'(if0.addr), 39);

    // Level 1 checkerboard with skip_empty: nothing is empty, so no skips.
    run0(2'd1, 1'b0, 1'b1);
    chk("l1_done_cyc", done_cyc, 241);
    chk("l1_h0", wr_h[0], 1);
    chk("l1_h1", wr_h[1], 2);
    chk("l1_h10", wr_h[10], 2);
    chk("l1_h11", wr_h[11], 1);
    chk("l1_draws", n_draw, 40);

    // Level 0 with skip_empty: row 3 is empty and skipped.
    run0(2'd0, 1'b0, 1'b1);
    chk("skip_done_cyc", done_cyc, 201);
    chk("skip_writes", n_wr, 40);
    chk("skip_draws", n_draw, 30);
    chk("skip_drawn29", drawn[29], 1);
    chk("skip_drawn30", drawn[30], 0);
    chk("skip_drawn39", drawn[39], 0);
    chk("skip_h30", wr_h[30], 0);
    chk("skip_x35", wr_x[35], 176);

    // Clear mode overrides level 3.
    run0(2'd3, 1'b1, 1'b0);
    hsum = 0;
    for (int i = 0; i < 40; i++) hsum += (wr_h[i] != 0) ? 1 : 0;
    chk("clr_nonzero_h", hsum, 0);
    chk("clr_writes", n_wr, 40);
    chk("clr_draws", n_draw, 40);
    chk("clr_done_cyc", done_cyc, 241);

    // Abort during WAIT of slot 5.
    @(negedge clk);
    if0.level = 2; if0.clear = 0; if0.skip_empty = 0; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (if0.addr == 10'd5 && if0.busy && !if0.draw && !if0.we) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_wait", found, 1);
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    chk("abort_busy", int'(if0.busy), 0);
    chk("abort_draw", int'(if0.draw), 0);
    chk("abort_we", int'(if0.we), 0);
    chk("abort_addr_hold", int'(if0.addr), 5);
    cnt_we = 0; cnt_done = 0; cnt_busy = 0;
    repeat (60) begin
      @(negedge clk);
      cnt_we += int'(if0.we); cnt_done += int'(if0.done); cnt_busy += int'(if0.busy);
    end
    chk("abort_no_we", cnt_we, 0);
    chk("abort_no_done", cnt_done, 0);
    chk("abort_no_busy", cnt_busy, 0);

    // start and abort together in IDLE: the start is dropped.
    if0.start = 1'b1; if0.abort = 1'b1;
    @(negedge clk);
    if0.start = 1'b0; if0.abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", int'(if0.busy), 0);

    run0(2'd2, 1'b0, 1'b0);
    chk("restart_addr0", first_addr, 0);
    chk("restart_done_cyc", done_cyc, 241);
    chk("restart_h20", wr_h[20], 1);

    // One slot, zero delay, start held through busy.
    @(negedge clk);
    if1.level = 3; if1.start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      s_draw[n] = int'(if1.draw); s_we[n] = int'(if1.we); s_done[n] = int'(if1.done);
      s_busy[n] = int'(if1.busy); s_h[n] = int'(if1.health);
      s_x[n] = int'(if1.x_out); s_y[n] = int'(if1.y_out);
      if (n == 3) if1.start = 1'b0;
    end
    chk("small_c1_draw", s_draw[1], 1);
    chk("small_c1_busy", s_busy[1], 1);
    chk("small_c2_we", s_we[2], 1);
    chk("small_c2_h", s_h[2], 3);
    chk("small_c2_x", s_x[2], 16);
    chk("small_c2_y", s_y[2], 8);
    chk("small_c3_done", s_done[3], 1);
    chk("small_c3_busy", s_busy[3], 0);
    cnt_done = 0; cnt_busy = 0; cnt_we = 0;
    for (int n = 1; n <= 10; n++) begin
      cnt_done += s_done[n];
      cnt_we += s_we[n];
      if (n >= 4) cnt_busy += s_busy[n];
    end
    chk("small_one_done", cnt_done, 1);
    chk("small_one_we", cnt_we, 1);
    chk("small_no_restart", cnt_busy, 0);

    // Reset in the middle of a load.
    @(negedge clk);
    if0.level = 0; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_busy_before", int'(if0.busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk_zero0("midrst");
    resetn = 1'b1;
    cnt_we = 0;
    repeat (30) begin
      @(negedge clk);
      cnt_we += int'(if0.we);
    end
    chk("midrst_no_we", cnt_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
